// File: rtl/vga_text_writer_if.sv
// vga_text_writer_if: byte stream from a CPU-side source into the text writer.
interface vga_text_writer_if;
    logic [7:0] char_data;
    logic       char_valid;
    logic       char_ready;
    logic [7:0] attr;
    modport master (output char_data, char_valid, attr, input char_ready);
    modport slave  (input char_data, char_valid, attr, output char_ready);
endinterface

// File: rtl/vga_text_writer.sv
// vga_text_writer: turns a byte stream into char/colour RAM write cycles, keeping a cursor.
module vga_text_writer #(
    parameter int COLS = 50,
    parameter int ROWS = 37
) (
    input  logic                 sys_clk,
    input  logic                 reset,
    vga_text_writer_if.slave     s,
    output logic [12:0]          wr_addr,
    output logic [7:0]           wr_data,
    output logic                 wr_en,
    output logic [5:0]           cursor_col,
    output logic [5:0]           cursor_row,
    output logic                 busy
);
    localparam logic [5:0] CMAX = 6'(COLS - 1);
    localparam logic [5:0] RMAX = 6'(ROWS - 1);

    typedef enum logic [2:0] {IDLE, WR_CHAR, WR_ATTR, CLR_ROW, CLR_ALL} state_t;
    state_t state, state_n;
    logic [5:0] col, col_n, row, row_n, cc, cc_n, cr, cr_n, rnext;
    logic [7:0] ch, ch_n, at, at_n;
    logic       ph, ph_n, adv, adv_n;

    assign s.char_ready = (state == IDLE);
    assign busy         = ~s.char_ready;
    assign cursor_col   = col;
    assign cursor_row   = row;
    assign rnext        = (row == RMAX) ? 6'd0 : row + 6'd1;

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state <= IDLE;
            col   <= '0;
            row   <= '0;
            ch    <= '0;
            at    <= '0;
            cc    <= '0;
            cr    <= '0;
            ph    <= 1'b0;
            adv   <= 1'b0;
        end else begin
            state <= state_n;
            col   <= col_n;
            row   <= row_n;
            ch    <= ch_n;
            at    <= at_n;
            cc    <= cc_n;
            cr    <= cr_n;
            ph    <= ph_n;
            adv   <= adv_n;
        end
    end

    always_comb begin
        state_n = state;
        col_n   = col;
        row_n   = row;
        ch_n    = ch;
        at_n    = at;
        cc_n    = cc;
        cr_n    = cr;
        ph_n    = ph;
        adv_n   = adv;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        case (state)
            IDLE: if (s.char_valid) begin
                at_n  = s.attr;
                ch_n  = s.char_data;
                adv_n = 1'b1;
                cc_n  = '0;
                ph_n  = 1'b0;
                if (s.char_data >= 8'h20) state_n = WR_CHAR;
                else if (s.char_data == 8'h0D) col_n = '0;
                else if (s.char_data == 8'h0A) begin
                    col_n   = '0;
                    row_n   = rnext;
                    cr_n    = rnext;
                    state_n = CLR_ROW;
                end else if (s.char_data == 8'h08 && col != 6'd0) begin
                    // backspace erases in place: blank at the new column, no advance
                    col_n   = col - 6'd1;
                    ch_n    = 8'h20;
                    adv_n   = 1'b0;
                    state_n = WR_CHAR;
                end else if (s.char_data == 8'h0C) begin
                    cr_n    = '0;
                    state_n = CLR_ALL;
                end
            end
            WR_CHAR: begin
                wr_en   = 1'b1;
                wr_addr = {1'b0, row, col};
                wr_data = ch;
                state_n = WR_ATTR;
            end
            WR_ATTR: begin
                wr_en   = 1'b1;
                wr_addr = {1'b1, row, col};
                wr_data = at;
                state_n = IDLE;
                if (adv && col == CMAX) begin
                    col_n   = '0;
                    row_n   = rnext;
                    cr_n    = rnext;
                    state_n = CLR_ROW;
                end else if (adv) col_n = col + 6'd1;
            end
            CLR_ROW, CLR_ALL: begin
                wr_en   = 1'b1;
                wr_addr = {ph, cr, cc};
                wr_data = ph ? at : 8'h20;
                ph_n    = ~ph;
                if (ph) begin
                    cc_n = (cc == CMAX) ? 6'd0 : cc + 6'd1;
                    if (cc == CMAX) begin
                        if (state == CLR_ROW || cr == RMAX) begin
                            state_n = IDLE;
                            if (state == CLR_ALL) begin
                                col_n = '0;
                                row_n = '0;
                            end
                        end else cr_n = cr + 6'd1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_vga_text_writer.sv
// tb_vga_text_writer: directed checks of the text writer at 50x37.
module tb_vga_text_writer;
    logic        sys_clk = 1'b0;
    logic        reset   = 1'b1;
    logic [12:0] wr_addr;
    logic [7:0]  wr_data;
    logic        wr_en, busy;
    logic [5:0]  cursor_col, cursor_row;
    logic [20:0] wlog[$];
    int          passed = 0, total = 0, cyc;

    vga_text_writer_if bus ();

    vga_text_writer dut (
        .sys_clk   (sys_clk),
        .reset     (reset),
        .s         (bus),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_en     (wr_en),
        .cursor_col(cursor_col),
        .cursor_row(cursor_row),
        .busy      (busy)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) if (!reset && wr_en) wlog.push_back({wr_addr, wr_data});

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic chk_wr(input string tag, input int idx, input logic [12:0] a, input logic [7:0] d);
        chk(tag, (idx < wlog.size()) ? {11'd0, wlog[idx]} : 32'hFFFF_FFFF, {11'd0, a, d});
    endtask

    task automatic send(input logic [7:0] d, input logic [7:0] a);
        bus.char_data  = d;
        bus.attr       = a;
        bus.char_valid = 1'b1;
        @(negedge sys_clk);
        bus.char_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        for (int i = 0; i < budget && !bus.char_ready; i++) @(negedge sys_clk);
        chk(tag, bus.char_ready, 1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge sys_clk);
        reset = 1'b0;
    endtask

    initial begin
        bus.char_valid = 1'b0;
        bus.char_data  = '0;
        bus.attr       = '0;
        @(negedge sys_clk);
        do_reset();
        chk("rst_ready", bus.char_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_addr", wr_addr, 0);
        chk("rst_data", wr_data, 0);
        chk("rst_cursor", {cursor_row, cursor_col}, 0);

        wlog.delete();
        send(8'h41, 8'h9A);
        chk("a_cyc1_ready", bus.char_ready, 0);
        chk("a_cyc1_wr", {wr_en, wr_addr, wr_data}, {1'b1, 13'h0000, 8'h41});
        @(negedge sys_clk);
        chk("a_cyc2_wr", {wr_en, wr_addr, wr_data}, {1'b1, 13'h1000, 8'h9A});
        chk("a_cyc2_busy", busy, 1);
        @(negedge sys_clk);
        chk("a_ready_back", bus.char_ready, 1);
        chk("a_cursor", {cursor_row, cursor_col}, {6'd0, 6'd1});
        chk("a_nwrites", wlog.size(), 2);

        do_reset();
        wlog.delete();
        for (int i = 0; i < 50; i++) begin
            send(8'h30, 8'h1F);
            wait_idle("row_idle", 200);
        end
        chk("row_nwrites", wlog.size(), 200);
        chk_wr("row_last_char", 98, 13'h0031, 8'h30);
        chk_wr("row_last_attr", 99, 13'h1031, 8'h1F);
        chk_wr("row_clr_first", 100, 13'h0040, 8'h20);
        chk_wr("row_clr_first_a", 101, 13'h1040, 8'h1F);
        chk_wr("row_clr_last_c", 198, 13'h0071, 8'h20);
        chk_wr("row_clr_last_a", 199, 13'h1071, 8'h1F);
        chk("row_cursor", {cursor_row, cursor_col}, {6'd1, 6'd0});

        wlog.delete();
        send(8'h0C, 8'h07);
        cyc = 0;
        while (!bus.char_ready && cyc < 5000) begin
            cyc++;
            @(negedge sys_clk);
        end
        chk("ff_busy_cycles", cyc, 3700);
        chk("ff_nwrites", wlog.size(), 3700);
        chk_wr("ff_first", 0, 13'h0000, 8'h20);
        chk_wr("ff_last", 3699, 13'h1931, 8'h07);
        chk("ff_cursor", {cursor_row, cursor_col}, 0);

        wlog.delete();
        send(8'h08, 8'h55);
        wait_idle("bs0_idle", 10);
        chk("bs0_nwrites", wlog.size(), 0);
        chk("bs0_cursor", {cursor_row, cursor_col}, 0);
        for (int i = 0; i < 3; i++) begin
            send(8'h41 + 8'(i), 8'h07);
            wait_idle("abc_idle", 10);
        end
        wlog.delete();
        send(8'h08, 8'h55);
        chk("bs_cursor_at_accept", cursor_col, 2);
        wait_idle("bs_idle", 10);
        chk("bs_nwrites", wlog.size(), 2);
        chk_wr("bs_char", 0, 13'h0002, 8'h20);
        chk_wr("bs_attr", 1, 13'h1002, 8'h55);
        chk("bs_cursor", {cursor_row, cursor_col}, {6'd0, 6'd2});

        for (int i = 0; i < 36; i++) begin
            send(8'h0A, 8'h07);
            wait_idle("lf_idle", 200);
        end
        chk("lf36_cursor", {cursor_row, cursor_col}, {6'd36, 6'd0});
        wlog.delete();
        send(8'h0A, 8'h3C);
        wait_idle("lfwrap_idle", 200);
        chk("lfwrap_nwrites", wlog.size(), 100);
        chk_wr("lfwrap_first", 0, 13'h0000, 8'h20);
        chk_wr("lfwrap_last", 99, 13'h1031, 8'h3C);
        chk("lfwrap_cursor", {cursor_row, cursor_col}, 0);

        for (int i = 0; i < 7; i++) begin
            send(8'h78, 8'h07);
            wait_idle("x_idle", 10);
        end
        chk("cr_pre_col", cursor_col, 7);
        wlog.delete();
        send(8'h0D, 8'h07);
        chk("cr_col_at_accept", cursor_col, 0);
        chk("cr_ready", bus.char_ready, 1);
        chk("cr_nwrites", wlog.size(), 0);
        send(8'h79, 8'h07);
        wait_idle("y_idle", 10);
        wlog.delete();
        send(8'h01, 8'h07);
        wait_idle("ctl_idle", 10);
        chk("ctl_nwrites", wlog.size(), 0);
        chk("ctl_cursor", {cursor_row, cursor_col}, {6'd0, 6'd1});

        send(8'h0C, 8'h07);
        repeat (500) @(negedge sys_clk);
        chk("mid_clr_busy", busy, 1);
        reset = 1'b1;
        @(negedge sys_clk);
        reset = 1'b0;
        chk("rst_mid_wr_en", wr_en, 0);
        chk("rst_mid_ready", bus.char_ready, 1);
        chk("rst_mid_cursor", {cursor_row, cursor_col}, 0);
        wlog.delete();
        send(8'h41, 8'h9A);
        wait_idle("post_rst_idle", 10);
        chk_wr("post_rst_char", 0, 13'h0000, 8'h41);
        chk_wr("post_rst_attr", 1, 13'h1000, 8'h9A);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
